// File: rtl/type_pkg.sv
// Shared bus types and arbiter ownership encoding used by the SoC bus front end.
package type_pkg;

    typedef logic [31:0] MemAddrBus;
    typedef logic [31:0] MemBus;

    localparam MemBus ZeroWord = 32'h0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M0 = 2'd1,
        OWN_M1 = 2'd2
    } arb_own_t;

    function automatic arb_own_t own_of(input logic m);
        return m ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin ownership FSM with a bounded tenure under contention.
module arb_rr2
    import type_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output arb_own_t   own
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    logic          last;
    logic [HW-1:0] hcnt;
    logic          cur;
    logic          mine;
    logic          other;
    logic          expire;
    logic          idle_pick;

    assign cur    = (own == OWN_M1);
    assign mine   = req[cur];
    assign other  = req[~cur];
    assign expire = (hcnt == HW'(MAX_HOLD - 1));
    // From IDLE: m1 wins if it is alone, or on a tie when m0 was the last owner.
    assign idle_pick = req[1] & (~req[0] | ~last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own  <= IDLE;
            last <= 1'b1;
            hcnt <= '0;
        end else begin
            case (own)
                IDLE: begin
                    hcnt <= '0;
                    if (|req) begin
                        own  <= own_of(idle_pick);
                        last <= idle_pick;
                    end
                end
                OWN_M0, OWN_M1: begin
                    if (!mine || (other && expire)) begin
                        hcnt <= '0;
                        if (other) begin
                            own  <= own_of(~cur);
                            last <= ~cur;
                        end else begin
                            own <= IDLE;
                        end
                    end else if (other) begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: begin
                    own  <= IDLE;
                    hcnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: round-robin ownership plus the owner-to-bus channel mux.
module bus_arbiter
    import type_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m0_req,
    input  logic       m1_req,
    output logic       m0_gnt,
    output logic       m1_gnt,
    input  MemAddrBus  m0_waddr,
    input  MemBus      m0_wdata,
    input  logic [3:0] m0_we,
    input  MemAddrBus  m0_raddr,
    output MemBus      m0_rdata,
    input  MemAddrBus  m1_waddr,
    input  MemBus      m1_wdata,
    input  logic [3:0] m1_we,
    input  MemAddrBus  m1_raddr,
    output MemBus      m1_rdata,
    output MemAddrBus  b_waddr,
    output MemBus      b_wdata,
    output logic [3:0] b_we,
    output MemAddrBus  b_raddr,
    input  MemBus      b_rdata
);

    arb_own_t own;

    arb_rr2 #(.MAX_HOLD(MAX_HOLD)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({m1_req, m0_req}),
        .own   (own)
    );

    assign m0_gnt = (own == OWN_M0);
    assign m1_gnt = (own == OWN_M1);

    // Only the owner's channels reach the bus, so a stray we from the other master is dropped.
    always_comb begin
        b_waddr  = ZeroWord;
        b_wdata  = ZeroWord;
        b_we     = 4'h0;
        b_raddr  = ZeroWord;
        m0_rdata = ZeroWord;
        m1_rdata = ZeroWord;
        case (own)
            OWN_M0: begin
                b_waddr  = m0_waddr;
                b_wdata  = m0_wdata;
                b_we     = m0_we;
                b_raddr  = m0_raddr;
                m0_rdata = b_rdata;
            end
            OWN_M1: begin
                b_waddr  = m1_waddr;
                b_wdata  = m1_wdata;
                b_we     = m1_we;
                b_raddr  = m1_raddr;
                m1_rdata = b_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, async reset sequence, random traffic vs a model.
module tb_bus_arbiter;

    localparam int MH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req, m0_gnt, m1_gnt;
    logic [31:0] m0_waddr, m0_wdata, m0_raddr, m0_rdata;
    logic [31:0] m1_waddr, m1_wdata, m1_raddr, m1_rdata;
    logic [3:0]  m0_we, m1_we, b_we;
    logic [31:0] b_waddr, b_wdata, b_raddr, b_rdata;

    bus_arbiter #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_raddr(m0_raddr), .m0_rdata(m0_rdata),
        .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_raddr(m1_raddr), .m1_rdata(m1_rdata),
        .b_waddr(b_waddr), .b_wdata(b_wdata), .b_we(b_we), .b_raddr(b_raddr), .b_rdata(b_rdata)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: who holds the bus (-1 none), who held it last, cycles held under contention.
    int owner;
    int mlast;
    int run;

    typedef struct {
        logic       rst;
        logic       r0, r1;
        logic [3:0] we0, we1;
        logic       g0, g1;
        logic [3:0] bwe;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        owner = -1;
        mlast = 1;
        run   = 0;
    endtask

    task automatic model_clock(input logic r0, input logic r1);
        int nxt;
        logic rq [2];
        rq[0] = r0;
        rq[1] = r1;
        if (owner < 0) begin
            if (r0 && r1)  nxt = 1 - mlast;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
            else           nxt = -1;
        end else if (!rq[owner]) begin
            nxt = rq[1-owner] ? 1 - owner : -1;
        end else if (rq[1-owner] && run + 1 >= MH) begin
            nxt = 1 - owner;
        end else begin
            nxt = owner;
            if (rq[1-owner]) run++;
        end
        if (nxt != owner) begin
            run = 0;
            if (nxt >= 0) mlast = nxt;
        end
        owner = nxt;
    endtask

    task automatic check_outputs();
        logic [31:0] ew, ed, er, e0, e1;
        logic [3:0]  ewe;
        ew = 0; ed = 0; er = 0; ewe = 0; e0 = 0; e1 = 0;
        if (owner == 0) begin
            ew = m0_waddr; ed = m0_wdata; ewe = m0_we; er = m0_raddr; e0 = b_rdata;
        end else if (owner == 1) begin
            ew = m1_waddr; ed = m1_wdata; ewe = m1_we; er = m1_raddr; e1 = b_rdata;
        end
        chk("m0_gnt",   {31'b0, m0_gnt}, {31'b0, owner == 0});
        chk("m1_gnt",   {31'b0, m1_gnt}, {31'b0, owner == 1});
        chk("b_waddr",  b_waddr, ew);
        chk("b_wdata",  b_wdata, ed);
        chk("b_we",     {28'b0, b_we}, {28'b0, ewe});
        chk("b_raddr",  b_raddr, er);
        chk("m0_rdata", m0_rdata, e0);
        chk("m1_rdata", m1_rdata, e1);
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic finish_cycle();
        @(posedge clk);
        if (rst_n) model_clock(m0_req, m1_req);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic rst, input logic r0, input logic r1,
                                input logic [3:0] we0, input logic [3:0] we1,
                                input logic g0, input logic g1, input logic [3:0] bwe);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.we0 = we0; v.we1 = we1;
        v.g0 = g0; v.g1 = g1; v.bwe = bwe;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_waddr = 32'h1000_0010; m0_wdata = 32'h0A0A_0A0A; m0_raddr = 32'h1000_0100;
        m1_waddr = 32'h2000_0020; m1_wdata = 32'h0B0B_0B0B; m1_raddr = 32'h2000_0200;
        b_rdata  = 32'hDEAD_BEEF;
        model_reset();

        // Continuous contention: reset tie goes to m0, then tenures of MH cycles alternate.
        tbl.push_back(mk(1, 1, 1, 4'hF, 4'h3, 0, 0, 4'h0));
        tbl.push_back(mk(0, 1, 1, 4'hF, 4'h3, 0, 0, 4'h0));
        for (int i = 0; i < 3 * MH; i++)
            if ((i / MH) % 2 == 0) tbl.push_back(mk(0, 1, 1, 4'hF, 4'h3, 1, 0, 4'hF));
            else                   tbl.push_back(mk(0, 1, 1, 4'hF, 4'h3, 0, 1, 4'h3));
        // Handover: m0 releases after 3 cycles, m1 takes over the next cycle.
        tbl.push_back(mk(1, 1, 1, 4'hF, 4'h3, 0, 0, 4'h0));
        tbl.push_back(mk(0, 1, 1, 4'hF, 4'h3, 0, 0, 4'h0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 1, 4'hF, 4'h3, 1, 0, 4'hF));
        tbl.push_back(mk(0, 0, 1, 4'hF, 4'h3, 1, 0, 4'hF));
        tbl.push_back(mk(0, 0, 1, 4'hF, 4'h3, 0, 1, 4'h3));
        tbl.push_back(mk(0, 0, 1, 4'hF, 4'h3, 0, 1, 4'h3));
        // m0 alone for 20 cycles while m1 drives a stray we; then m1 requests but waits.
        tbl.push_back(mk(1, 1, 0, 4'h0, 4'hF, 0, 0, 4'h0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 4'hF, 0, 0, 4'h0));
        for (int i = 0; i < 20; i++) tbl.push_back(mk(0, 1, 0, 4'h0, 4'hF, 1, 0, 4'h0));
        for (int i = 0; i < 3; i++)  tbl.push_back(mk(0, 1, 1, 4'h0, 4'hF, 1, 0, 4'h0));

        @(negedge clk);
        foreach (tbl[k]) begin
            rst_n  = ~tbl[k].rst;
            m0_req = tbl[k].r0;
            m1_req = tbl[k].r1;
            m0_we  = tbl[k].we0;
            m1_we  = tbl[k].we1;
            if (tbl[k].rst) model_reset();
            #1;
            chk($sformatf("tbl%0d_m0_gnt", k), {31'b0, m0_gnt}, {31'b0, tbl[k].g0});
            chk($sformatf("tbl%0d_m1_gnt", k), {31'b0, m1_gnt}, {31'b0, tbl[k].g1});
            chk($sformatf("tbl%0d_b_we", k),   {28'b0, b_we},   {28'b0, tbl[k].bwe});
            check_outputs();
            finish_cycle();
        end

        // Async reset pulse between edges while m0 owns the bus.
        m0_req = 1; m1_req = 0; m0_we = 4'hF;
        finish_cycle();
        #1;
        chk("pre_rst_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_m0_gnt",  {31'b0, m0_gnt}, 32'd0);
        chk("async_b_waddr", b_waddr, 32'd0);
        chk("async_b_we",    {28'b0, b_we}, 32'd0);
        chk("async_m0_rdata", m0_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m0_req = 1; m1_req = 1;
        #1 check_outputs();
        finish_cycle();
        #1;
        chk("post_rst_tie_m0", {31'b0, m0_gnt}, 32'd1);
        chk("post_rst_tie_m1", {31'b0, m1_gnt}, 32'd0);
        check_outputs();
        finish_cycle();

        // Random traffic: sticky requests, fresh channel data every cycle.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) m0_req = ~m0_req;
            if ($urandom_range(0, 5) == 0) m1_req = ~m1_req;
            m0_waddr = $urandom; m0_wdata = $urandom; m0_raddr = $urandom; m0_we = 4'($urandom);
            m1_waddr = $urandom; m1_wdata = $urandom; m1_raddr = $urandom; m1_we = 4'($urandom);
            b_rdata  = $urandom;
            #1 check_outputs();
            finish_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
